// File: rtl/mcam_viol_responder_if.sv
// Wipe-port handshake between the violation responder (master) and the memory arbiter (slave).
interface mcam_viol_responder_if #(
  parameter int SIZE_MEM_ADDR = 15
);
  logic                   wipe_gnt;
  logic                   wipe_cen;
  logic [1:0]             wipe_wen;
  logic [SIZE_MEM_ADDR:0] wipe_addr;
  logic [15:0]            wipe_din;

  modport master (
    input  wipe_gnt,
    output wipe_cen, wipe_wen, wipe_addr, wipe_din
  );

  modport slave (
    output wipe_gnt,
    input  wipe_cen, wipe_wen, wipe_addr, wipe_din
  );
endinterface

// File: rtl/mcam_viol_responder.sv
// Violation responder: holds the core in PUC, zero-wipes the safe region, stretches reset, releases.
// Optional violation log (count, address, PC) is built only when MCAM_VIOL_LOG_EN is defined.
module mcam_viol_responder #(
  parameter int SIZE_MEM_ADDR = 15,
  parameter int LOW_SAFE      = 200,
  parameter int HIGH_SAFE     = 200,
  parameter int HOLD_CYCLES   = 16
) (
  input  logic                   mclk,
  input  logic                   reset_n,
  input  logic                   viol_req,
  input  logic [SIZE_MEM_ADDR:0] viol_addr,
  input  logic [15:0]            viol_pc,
  input  logic                   disable_debug,
  mcam_viol_responder_if.master  wipe,
  output logic                   puc_req,
  output logic                   wipe_busy,
  output logic [7:0]             viol_count,
  output logic [SIZE_MEM_ADDR:0] last_viol_addr,
  output logic [15:0]            last_viol_pc
);

  localparam int ADDR_W = SIZE_MEM_ADDR + 1;
  localparam int CNT_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam bit EMPTY  = (LOW_SAFE > HIGH_SAFE);

  typedef enum logic [1:0] {IDLE, CAPTURE, WIPE, HOLD} state_e;

  state_e              state_q, state_d;
  logic                puc_q, puc_d;
  logic                cen_q, cen_d;
  logic [1:0]          wen_q, wen_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    puc_d   = puc_q;
    cen_d   = cen_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (viol_req && !disable_debug) begin
          state_d = CAPTURE;
          puc_d   = 1'b1;
        end
      end
      CAPTURE: begin
        if (EMPTY) begin
          state_d = HOLD;
          cnt_d   = CNT_W'(HOLD_CYCLES - 1);
        end else begin
          state_d = WIPE;
          addr_d  = ADDR_W'(LOW_SAFE);
          cen_d   = 1'b0;
          wen_d   = 2'b00;
        end
      end
      WIPE: begin
        // Compare before incrementing so a region ending at all-ones never wraps.
        if (wipe.wipe_gnt) begin
          if (addr_q == ADDR_W'(HIGH_SAFE)) begin
            state_d = HOLD;
            cen_d   = 1'b1;
            wen_d   = 2'b11;
            cnt_d   = CNT_W'(HOLD_CYCLES - 1);
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          puc_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      puc_q   <= 1'b0;
      cen_q   <= 1'b1;
      wen_q   <= 2'b11;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      puc_q   <= puc_d;
      cen_q   <= cen_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign puc_req        = puc_q;
  assign wipe_busy      = puc_q;
  assign wipe.wipe_cen  = cen_q;
  assign wipe.wipe_wen  = wen_q;
  assign wipe.wipe_addr = addr_q;
  assign wipe.wipe_din  = 16'h0000;

`ifdef MCAM_VIOL_LOG_EN
  logic              viol_req_q;
  logic [7:0]        count_q, count_d;
  logic [ADDR_W-1:0] laddr_q, laddr_d;
  logic [15:0]       lpc_q, lpc_d;
  logic              accept, retrigger;

  // Idle accepts on level; while busy only a fresh rising edge counts, captures stay frozen.
  always_comb begin
    accept    = (state_q == IDLE) && viol_req && !disable_debug;
    retrigger = (state_q != IDLE) && viol_req && !viol_req_q && !disable_debug;
    count_d   = count_q;
    laddr_d   = laddr_q;
    lpc_d     = lpc_q;
    if ((accept || retrigger) && (count_q != 8'hFF)) count_d = count_q + 8'd1;
    if (accept) begin
      laddr_d = viol_addr;
      lpc_d   = viol_pc;
    end
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      viol_req_q <= 1'b0;
      count_q    <= '0;
      laddr_q    <= '0;
      lpc_q      <= '0;
    end else begin
      viol_req_q <= viol_req;
      count_q    <= count_d;
      laddr_q    <= laddr_d;
      lpc_q      <= lpc_d;
    end
  end

  assign viol_count     = count_q;
  assign last_viol_addr = laddr_q;
  assign last_viol_pc   = lpc_q;
`else
  logic unused_log_inputs;
  assign unused_log_inputs = ^{viol_addr, viol_pc};
  assign viol_count        = '0;
  assign last_viol_addr    = '0;
  assign last_viol_pc      = '0;
`endif

endmodule

// File: doc/mcam_viol_responder.md
Name: mcam_viol_responder

Overview:
- Responder side of the memory-access protection interface.
- Consumes the violation request raised by the access monitor when safe memory is touched from outside the safe code window.
- On a violation it holds the core in reset, zero-wipes the safe memory region word by word through a memory-arbiter handshake, stretches the reset, then releases the core.
- Sits between the access monitor, the memory arbiter and the core's power-up-clear (PUC) input.

Parameters:
- SIZE_MEM_ADDR, 15: MSB index of the word addresses; address buses are [SIZE_MEM_ADDR:0].
- LOW_SAFE, 200: first word address of the safe region to wipe (inclusive).
- HIGH_SAFE, 200: last word address of the safe region to wipe (inclusive).
- HOLD_CYCLES, 16: cycles puc_req stays high after the wipe completes. Must be ≥1.

Ports:
- mclk  input  1  clock, single domain.
- reset_n  input  1  asynchronous active-low reset.
- viol_req  input  1  violation request from the access monitor (level, sampled on each mclk rising edge).
- viol_addr  input  SIZE_MEM_ADDR+1  memory address of the offending access.
- viol_pc  input  16  instruction address at the violation.
- disable_debug  input  1  high: viol_req ignored.
- wipe_gnt  input  1  arbiter grant; the current wipe word is written on a cycle with wipe_cen low and wipe_gnt high.
- puc_req  output  1  reset request to the core.
- wipe_cen  output  1  active-low memory chip enable.
- wipe_wen  output  2  active-low byte write enables.
- wipe_addr  output  SIZE_MEM_ADDR+1  wipe word address.
- wipe_din  output  16  write data, always 16'h0000.
- wipe_busy  output  1  high in any state other than IDLE.
- viol_count  output  8  saturating count of accepted violations.
- last_viol_addr  output  SIZE_MEM_ADDR+1  captured viol_addr.
- last_viol_pc  output  16  captured viol_pc.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE, puc_req=0, wipe_cen=1, wipe_wen=2'b11, wipe_addr=0, wipe_busy=0.
  - viol_count=0, last_viol_addr=0, last_viol_pc=0, hold counter=0.
  - Reset mid-operation aborts the wipe immediately, with no completion.
- All outputs are registered except wipe_din, which is a constant 0.
- FSM states IDLE, CAPTURE, WIPE, HOLD:
  - IDLE: when viol_req=1 and disable_debug=0 at an edge, go to CAPTURE.
    - puc_req=1 from the next cycle (1-cycle latency).
    - Capture viol_addr and viol_pc; increment viol_count.
  - CAPTURE, one cycle:
    - Load wipe_addr=LOW_SAFE and go to WIPE.
    - If LOW_SAFE>HIGH_SAFE (empty region), go directly to HOLD with the hold counter loaded.
  - WIPE: wipe_cen=0, wipe_wen=2'b00.
    - On an edge with wipe_gnt=1:
      - wipe_addr==HIGH_SAFE: go to HOLD; wipe_cen and wipe_wen deassert; hold counter = HOLD_CYCLES-1.
      - otherwise: wipe_addr+1.
    - wipe_gnt=0 stalls, with address and strobes held.
  - HOLD: decrement the counter each cycle; at 0, go to IDLE and drop puc_req. HOLD therefore lasts exactly HOLD_CYCLES cycles.
- puc_req is high in every state except IDLE; wipe_busy equals puc_req.
- viol_req while busy (any state other than IDLE):
  - No restart; the sequence continues.
  - viol_count still increments (one per rising edge of viol_req, edge-detected).
  - Capture registers are not overwritten.
- viol_count saturates at 255; no wrap.
- disable_debug high in IDLE: no action. Going high mid-sequence has no effect; the sequence completes.
- wipe_addr never exceeds HIGH_SAFE. Region end at all-ones does not wrap because the comparison happens before the increment.

Optional Feature:
- Macro MCAM_VIOL_LOG_EN.
- Defined: viol_count, last_viol_addr and last_viol_pc are implemented as described.
- Undefined: those registers are not built, the outputs are tied to 0, and the FSM is unchanged.

Test Plan:
- Basic sequence:
  - Stimulus: LOW_SAFE=8, HIGH_SAFE=11, HOLD_CYCLES=4, wipe_gnt=1, 1-cycle viol_req pulse at cycle 0 with viol_addr=9 and viol_pc=16'h0040.
  - Required: puc_req high in cycles 1–9.
  - Required: wipe writes to addresses 8,9,10,11 in cycles 2–5, each with wipe_din=0.
  - Required: last_viol_addr=9, last_viol_pc=16'h0040, viol_count=1.
  - Required: IDLE at cycle 10.
- Grant stall: same setup, wipe_gnt=0 for 3 cycles while wipe_addr=10 → address 10 held with wipe_cen=0 for 4 cycles; puc_req high 12 cycles total.
- Gating and re-trigger:
  - disable_debug=1 with viol_req=1 → puc_req stays 0 and viol_count stays 0.
  - A second viol_req pulse during WIPE → sequence length unchanged, viol_count=2, captures unchanged.
- Async reset mid-WIPE: reset_n low at wipe_addr=9 → puc_req=0, wipe_cen=1 and viol_count=0 immediately, without waiting for an edge; after release, IDLE.
- Empty region: LOW_SAFE=12, HIGH_SAFE=11, HOLD_CYCLES=4 → no wipe_cen low; puc_req high 5 cycles (CAPTURE plus HOLD).
- Saturation: 300 accepted violations → viol_count=255; with MCAM_VIOL_LOG_EN undefined, all log outputs read 0.
